// File: rtl/pckt_src_pkg.sv
// Shared types and helpers for the programmable packet stimulus source.
package pckt_src_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PKT,
    SEND,
    GAP,
    FIN
  } state_e;

  typedef struct packed {
    logic        err;
    logic [15:0] len;
  } len_entry_t;

  // Beats needed to carry len bytes on a bus of iw bytes per beat.
  function automatic int unsigned beats_of(input logic [15:0] len, input int unsigned iw);
    return (32'(len) + iw - 1) / iw;
  endfunction

  // Low e lanes flagged invalid, never more than iw lanes.
  function automatic logic [63:0] empty_mask(input int unsigned e, input int unsigned iw);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < e && i < iw) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pckt_src_if.sv
// Load/control/stream bundle of the packet source; master = generator side.
interface pckt_src_if #(
  parameter int IWIDTH    = 8,
  parameter int NUM_PKTS  = 4,
  parameter int MAX_BEATS = 16
) ();
  localparam int CW = $clog2(NUM_PKTS + 1);
  localparam int AW = $clog2(NUM_PKTS * MAX_BEATS);

  logic                  start;
  logic [CW-1:0]         num_pkts;
  logic                  wr_en;
  logic                  wr_sel;
  logic [AW-1:0]         wr_addr;
  logic [IWIDTH*8-1:0]   wr_data;
  logic                  ready_out_b;
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic [IWIDTH*8-1:0]   in_data;
  logic [IWIDTH-1:0]     in_empty;
  logic                  in_error;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, num_pkts, wr_en, wr_sel, wr_addr, wr_data, ready_out_b,
    output in_valid, in_sop, in_eop, in_data, in_empty, in_error, busy, done
  );

  modport slave (
    output start, num_pkts, wr_en, wr_sel, wr_addr, wr_data, ready_out_b,
    input  in_valid, in_sop, in_eop, in_data, in_empty, in_error, busy, done
  );
endinterface

// File: rtl/pckt_src_mem.sv
// Beat storage: synchronous write, combinational read.
module pckt_src_mem #(
  parameter int DEPTH = 64,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_tb,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset so loaded packets survive a reset and it maps onto RAM.
  always_ff @(posedge clk_tb) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pckt_src_gen.sv
// Replays loaded packets onto the decoder input stream with backpressure and gaps.
// Define PCKT_SRC_ERR_INJ_EN to drive in_error from the per-packet table err bit.
module pckt_src_gen
  import pckt_src_pkg::*;
#(
  parameter int IWIDTH    = 8,
  parameter int NUM_PKTS  = 4,
  parameter int MAX_BEATS = 16,
  parameter int IDLE_GAP  = 2
) (
  input logic        clk_tb,
  input logic        rstb,
  pckt_src_if.master bus
);
  localparam int DW = IWIDTH * 8;
  localparam int CW = $clog2(NUM_PKTS + 1);
  localparam int AW = $clog2(NUM_PKTS * MAX_BEATS);
  localparam int PW = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int EW = $clog2(IWIDTH + 1);
  localparam int GW = $clog2(IDLE_GAP + 2);
  localparam logic [15:0] MAX_LEN = 16'(MAX_BEATS * IWIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   n_pkts_q, n_pkts_d, pkt_idx_q, pkt_idx_d;
  logic [BW-1:0]   beat_q, beat_d, beats_q, beats_d;
  logic [EW-1:0]   e_q, e_d;
  logic            pkt_err_q, pkt_err_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IWIDTH-1:0] empty_q, empty_d;
  logic            busy_q, busy_d, done_q, done_d;

  len_entry_t      len_tab [NUM_PKTS];
  len_entry_t      cur, wr_entry;
  logic            load_ok, last_pkt;
  logic [15:0]     len_c;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata;

  assign load_ok  = (state_q == IDLE) || (state_q == FIN);
  assign cur      = len_tab[pkt_idx_q[PW-1:0]];
  assign len_c    = (cur.len > MAX_LEN) ? MAX_LEN : cur.len;
  assign last_pkt = (pkt_idx_q + CW'(1)) >= n_pkts_q;
  assign raddr    = AW'(int'(pkt_idx_q) * MAX_BEATS + int'(beat_q));

  always_comb begin
    wr_entry     = '0;
    wr_entry.len = bus.wr_data[15:0];
`ifdef PCKT_SRC_ERR_INJ_EN
    wr_entry.err = bus.wr_data[16];
`else
    wr_entry.err = 1'b0;
`endif
  end

  always_ff @(posedge clk_tb) begin
    if (bus.wr_en && bus.wr_sel && load_ok && int'(bus.wr_addr) < NUM_PKTS)
      len_tab[bus.wr_addr[PW-1:0]] <= wr_entry;
  end

  pckt_src_mem #(.DEPTH(NUM_PKTS * MAX_BEATS), .DW(DW), .AW(AW)) u_mem (
    .clk_tb  (clk_tb),
    .we_i    (bus.wr_en && !bus.wr_sel && load_ok),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // NOTE: every _d gets its hold/idle value first so no path infers a latch.
  always_comb begin
    int unsigned nb;
    state_d   = state_q;
    n_pkts_d  = n_pkts_q;
    pkt_idx_d = pkt_idx_q;
    beat_d    = beat_q;
    beats_d   = beats_q;
    e_d       = e_q;
    pkt_err_d = pkt_err_q;
    gap_d     = gap_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    empty_d   = '0;
    data_d    = data_q;
    nb        = beats_of(len_c, IWIDTH);

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (bus.start) begin
          n_pkts_d  = (bus.num_pkts > CW'(NUM_PKTS)) ? CW'(NUM_PKTS) : bus.num_pkts;
          pkt_idx_d = '0;
          state_d   = (n_pkts_d == '0) ? FIN : LOAD_PKT;
        end
      end
      LOAD_PKT: begin
        beat_d    = '0;
        beats_d   = BW'(nb);
        e_d       = EW'(nb * IWIDTH - 32'(len_c));
        pkt_err_d = cur.err;
        if (len_c == '0) begin
          pkt_idx_d = pkt_idx_q + CW'(1);
          state_d   = last_pkt ? FIN : LOAD_PKT;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        // Beat index only moves on a cycle where the sink is ready.
        if (!bus.ready_out_b) begin
          valid_d = 1'b1;
          data_d  = rdata;
          sop_d   = (beat_q == '0);
          eop_d   = (beat_q == beats_q - BW'(1));
          beat_d  = beat_q + BW'(1);
          if (eop_d) begin
            empty_d = IWIDTH'(empty_mask(32'(e_q), IWIDTH));
            err_d   = pkt_err_q;
            if (IDLE_GAP > 0) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              pkt_idx_d = pkt_idx_q + CW'(1);
              state_d   = last_pkt ? FIN : LOAD_PKT;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(IDLE_GAP - 1)) begin
          pkt_idx_d = pkt_idx_q + CW'(1);
          state_d   = last_pkt ? FIN : LOAD_PKT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD_PKT) || (state_d == SEND) || (state_d == GAP);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk_tb or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      n_pkts_q  <= '0;
      pkt_idx_q <= '0;
      beat_q    <= '0;
      beats_q   <= '0;
      e_q       <= '0;
      pkt_err_q <= 1'b0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      empty_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_pkts_q  <= n_pkts_d;
      pkt_idx_q <= pkt_idx_d;
      beat_q    <= beat_d;
      beats_q   <= beats_d;
      e_q       <= e_d;
      pkt_err_q <= pkt_err_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
      data_q    <= data_d;
      empty_q   <= empty_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_valid = valid_q;
  assign bus.in_sop   = sop_q;
  assign bus.in_eop   = eop_q;
  assign bus.in_data  = data_q;
  assign bus.in_empty = empty_q;
  assign bus.in_error = err_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
